// File: rtl/coin_feeder.sv
// Customer-side driver for the vending FSM: queues coins, presents each on
// coin_in with a timed next strobe, steps the machine with coin-less strobes,
// and tallies the soda and change events it observes while a transaction runs.
module coin_feeder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 8,
    parameter int unsigned MAX_STEPS = 6,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [1:0]       load_coin,
    output logic             load_ready,
    input  logic             start,
    input  logic             soda,
    input  logic [1:0]       coin_out,
    input  logic             check_coin_in,
    output logic [1:0]       coin_in,
    output logic             next,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] soda_count,
    output logic [CNT_W-1:0] change_count
);

    localparam int unsigned PTR_W  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam int unsigned CYC_W  = $clog2(SETUP_CYC + PULSE_CYC + GAP_CYC + 1);
    localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_STEP,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [STEP_W-1:0] step_cnt;

    logic [1:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [1:0]        head;

    logic              soda_q;
    logic [1:0]        coin_out_q;
    logic              soda_seen;
    logic              active;
    logic              soda_rise;
    logic              change_rise;

    assign full        = (occ == OCC_W'(DEPTH));
    assign empty       = (occ == '0);
    assign load_ready  = ~full;
    assign push        = load_valid && !full && (load_coin != 2'b00);
    assign pop         = (state == S_HOLD);
    assign head        = mem[rd_ptr];

    assign active      = (state != S_IDLE);
    assign soda_rise   = soda && !soda_q;
    assign change_rise = (coin_out != 2'b00) && (coin_out_q == 2'b00);

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= load_coin;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                occ <= occ + OCC_W'(1);
            end else if (!push && pop) begin
                occ <= occ - OCC_W'(1);
            end
        end
    end

    // Event monitor: edge-detect soda and change while a transaction is active
    always_ff @(posedge clk) begin
        if (reset) begin
            soda_q       <= 1'b0;
            coin_out_q   <= 2'b00;
            soda_count   <= '0;
            change_count <= '0;
            soda_seen    <= 1'b0;
        end else begin
            soda_q     <= soda;
            coin_out_q <= coin_out;
            if (active && soda_rise && (soda_count != '1)) begin
                soda_count <= soda_count + CNT_W'(1);
            end
            if (active && change_rise && (change_count != '1)) begin
                change_count <= change_count + CNT_W'(1);
            end
            if (state == S_DONE) begin
                soda_seen <= 1'b0;
            end else if (active && soda_rise) begin
                soda_seen <= 1'b1;
            end
        end
    end

    // Transaction sequencer with registered strobe outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cyc_cnt  <= '0;
            step_cnt <= '0;
            coin_in  <= 2'b00;
            next     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !empty) begin
                        state    <= S_SETUP;
                        cyc_cnt  <= '0;
                        step_cnt <= '0;
                        timeout  <= 1'b0;
                        coin_in  <= head;
                        next     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cyc_cnt == CYC_W'(SETUP_CYC - 1)) begin
                        state   <= S_PULSE;
                        cyc_cnt <= '0;
                        next    <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cyc_cnt == CYC_W'(PULSE_CYC - 1)) begin
                        state   <= S_HOLD;
                        cyc_cnt <= '0;
                        next    <= 1'b0;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                S_HOLD: begin
                    // head is popped by the FIFO block on this edge
                    state   <= S_GAP;
                    cyc_cnt <= '0;
                    coin_in <= 2'b00;
                end
                S_STEP: begin
                    if (cyc_cnt == CYC_W'(PULSE_CYC - 1)) begin
                        state   <= S_GAP;
                        cyc_cnt <= '0;
                        next    <= 1'b0;
                        if (step_cnt != STEP_W'(MAX_STEPS)) begin
                            step_cnt <= step_cnt + STEP_W'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                S_GAP: begin
                    if (cyc_cnt == CYC_W'(GAP_CYC - 1)) begin
                        cyc_cnt <= '0;
                        if (soda_seen) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (step_cnt == STEP_W'(MAX_STEPS)) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end else if (!empty && check_coin_in) begin
                            state   <= S_SETUP;
                            coin_in <= head;
                        end else begin
                            state <= S_STEP;
                            next  <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    cyc_cnt <= '0;
                    coin_in <= 2'b00;
                    next    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
